mem_arbiter_rr: RTL and testbench

MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

---
 rtl/mem_arbiter_rr.sv | 110 +++++++++++
 tb/tb_mem_arbiter_rr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter granting four cores access to one shared memory port.
// Each transaction runs IDLE -> BUSY (until mem_ready) -> RESP (done pulse).
module mem_arbiter_rr #(
    parameter int NCORE = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCORE-1:0]    core_req,
    input  logic [NCORE-1:0]    core_we,
    input  logic [NCORE*AW-1:0] core_addr,
    input  logic [NCORE*DW-1:0] core_wdata,
    output logic [NCORE-1:0]    core_done,
    output logic [DW-1:0]       core_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    input  logic                mem_ready,
    output logic [1:0]          grant_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] rr_ptr;
    logic [1:0] win;
    logic [1:0] idx;
    logic       any_req;

    // Scan downwards so the candidate closest to rr_ptr is written last.
    always_comb begin
        win     = rr_ptr;
        idx     = '0;
        any_req = |core_req;
        for (int k = NCORE - 1; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (core_req[idx]) begin
                win = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        core_done = '0;
        mem_req   = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                core_done[grant_id] = 1'b1;
                state_nxt           = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            grant_id   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_id  <= win;
                rr_ptr    <= win + 2'd1;
                mem_we    <= core_we[win];
                mem_addr  <= core_addr[win*AW +: AW];
                mem_wdata <= core_wdata[win*DW +: DW];
            end
            if (state == BUSY && mem_ready) begin
                core_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: vector table of single transactions
// plus hand sequences for fairness, withdrawal and mid-transaction reset.
module tb_mem_arbiter_rr;

    logic         clk;
    logic         reset;
    logic [3:0]   core_req;
    logic [3:0]   core_we;
    logic [127:0] core_addr;
    logic [127:0] core_wdata;
    logic [3:0]   core_done;
    logic [31:0]  core_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ready;
    logic [1:0]   grant_id;
    logic         busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter_rr #(.NCORE(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .core_req  (core_req),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_done (core_done),
        .core_rdata(core_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        int          waits;
        logic [31:0] rdata;
        logic [1:0]  g;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] addr_tab[4];
    logic [31:0] wdata_tab[4];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts from IDLE at a negedge with requests already driven.
    task automatic run_txn(input logic [1:0] g, input logic we,
                           input int waits, input logic [31:0] rdata,
                           input bit drop, input string name);
        logic [3:0] exp_done;
        exp_done    = '0;
        exp_done[g] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, " grant"}, 32'(grant_id), 32'(g));
        check({name, " mem_req"}, 32'(mem_req), 32'd1);
        check({name, " busy"}, 32'(busy), 32'd1);
        check({name, " we"}, 32'(mem_we), 32'(we));
        check({name, " addr"}, mem_addr, addr_tab[g]);
        check({name, " wdata"}, mem_wdata, wdata_tab[g]);
        for (int w = 0; w < waits; w++) begin
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0_0000;
            @(negedge clk);
            check({name, " wait req"}, 32'(mem_req), 32'd1);
            check({name, " wait addr"}, mem_addr, addr_tab[g]);
            check({name, " wait wdata"}, mem_wdata, wdata_tab[g]);
            check({name, " wait done"}, 32'(core_done), 32'd0);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        check({name, " done"}, 32'(core_done), 32'(exp_done));
        check({name, " rdata"}, core_rdata, rdata);
        check({name, " resp req"}, 32'(mem_req), 32'd0);
        if (drop) core_req[g] = 1'b0;
        @(negedge clk);
        check({name, " idle done"}, 32'(core_done), 32'd0);
        check({name, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        addr_tab  = '{32'h20, 32'h1000, 32'h100, 32'h3000};
        wdata_tab = '{32'h55, 32'hA1, 32'hA2, 32'hA3};
        vecs[0] = '{4'b0100, 4'b0000, 0, 32'hDEADBEEF, 2'd2};
        vecs[1] = '{4'b1001, 4'b0000, 0, 32'h1111_0001, 2'd3};
        vecs[2] = '{4'b1001, 4'b0000, 0, 32'h2222_0002, 2'd0};
        vecs[3] = '{4'b0001, 4'b0001, 3, 32'h3333_0003, 2'd0};
        vecs[4] = '{4'b0110, 4'b0110, 0, 32'h4444_0004, 2'd1};
        vecs[5] = '{4'b0011, 4'b0000, 2, 32'h5555_0005, 2'd0};
        vecs[6] = '{4'b1000, 4'b1000, 1, 32'h6666_0006, 2'd3};

        reset      = 1'b0;
        core_req   = '0;
        core_we    = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < 4; i++) begin
            core_addr[i*32 +: 32]  = addr_tab[i];
            core_wdata[i*32 +: 32] = wdata_tab[i];
        end
        repeat (2) @(negedge clk);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(core_done), 32'd0);
        check("rst addr", mem_addr, 32'd0);
        check("rst rdata", core_rdata, 32'd0);
        check("rst grant", 32'(grant_id), 32'd0);
        reset     = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle ready ignored", 32'(busy), 32'd0);
        check("idle mem_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b0;

        for (int v = 0; v < 7; v++) begin
            core_req = vecs[v].req;
            core_we  = vecs[v].we;
            run_txn(vecs[v].g, vecs[v].we[vecs[v].g], vecs[v].waits,
                    vecs[v].rdata, 1'b1, $sformatf("vec%0d", v));
            core_req = '0;
        end

        core_req = 4'b1111;
        core_we  = 4'b0000;
        for (int t = 0; t < 8; t++) begin
            run_txn(2'(t % 4), 1'b0, 0, 32'hF000_0000 + 32'(t), 1'b0,
                    $sformatf("fair%0d", t));
        end
        core_req = '0;
        @(negedge clk);

        core_req = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        check("wd grant", 32'(grant_id), 32'd1);
        core_req  = '0;
        mem_ready = 1'b0;
        @(negedge clk);
        check("wd hold req", 32'(mem_req), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        mem_ready = 1'b0;
        check("wd done", 32'(core_done), 32'b0010);
        @(negedge clk);
        check("wd done once", 32'(core_done), 32'd0);
        @(negedge clk);
        check("wd stay idle", 32'(busy), 32'd0);

        core_req = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        check("rb grant", 32'(grant_id), 32'd2);
        check("rb req", 32'(mem_req), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rb async req", 32'(mem_req), 32'd0);
        check("rb async busy", 32'(busy), 32'd0);
        check("rb async addr", mem_addr, 32'd0);
        core_req  = 4'b1010;
        mem_ready = 1'b1;
        @(negedge clk);
        check("rb no done", 32'(core_done), 32'd0);
        mem_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rb first grant", 32'(grant_id), 32'd1);
        check("rb mem_req", 32'(mem_req), 32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rb done", 32'(core_done), 32'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
